sap_core: RTL
=============

Name: sap_core

Overview:
- Parametrised SAP-class accumulator CPU core: fetch/decode/execute micro-sequencer, A/B registers, ALU with flags, PC, MAR, IR, internal RAM and output register in one block.
- Successor to the fixed 8-bit/16-word board CPU. Adds generic width and depth, variable-length instructions with early step reset, and a tick enable in place of a divided clock.
- Also adds a HALT/RUN state machine with single-step mode and a program-load port.
- Sits under the board top; the top drives tick, run and load, and displays out_o.

Parameters:
- DATA_W, 8, data/instruction word width. Opcode = bits [DATA_W-1:DATA_W-4]; operand = bits [DATA_W-5:0].
- ADDR_W, 4, PC/MAR/RAM address width. Must be <= DATA_W-4; operand is truncated to ADDR_W for addresses. RAM depth = 2**ADDR_W.

Ports:
- clk  in  1  core clock
- clr  in  1  asynchronous active-high reset
- tick  in  1  advance enable; micro-steps execute only on clk edges with tick=1
- run_i  in  1  one-cycle pulse: leave HALT
- step_mode  in  1  1 = return to HALT after each completed instruction
- prog_we  in  1  RAM write strobe; honoured only in HALT
- prog_addr  in  ADDR_W  load address
- prog_data  in  DATA_W  load data
- out_o  out  DATA_W  output register
- out_valid  out  1  one-clk pulse when out_o is written by OUT
- halted  out  1  1 in HALT state
- pc_o  out  ADDR_W  program counter
- a_o  out  DATA_W  accumulator
- cf  out  1  carry flag
- zf  out  1  zero flag
- step_o  out  3  current micro-step T0..T4

Behaviour:
- Reset (clr=1, async): state=HALT, halted=1. PC, MAR, IR, A, B, out_o, cf, zf, step_o all 0; out_valid=0. RAM contents are NOT cleared.
- HALT:
  - No micro-steps execute; tick is ignored.
  - prog_we=1 writes RAM[prog_addr] <= prog_data on that clk edge.
  - run_i=1 moves to RUN on the same edge with step=T0. If prog_we is also 1, the write completes on that edge as well.
- RUN:
  - prog_we and run_i are ignored.
  - On each tick edge the current micro-step executes, then step advances, or resets to T0 when the instruction completes (early step reset).
- Fetch, every instruction:
  - T0: MAR <= PC.
  - T1: IR <= RAM[MAR]; PC <= PC+1, wrapping 2**ADDR_W-1 -> 0.
- Execute (op = operand truncated to ADDR_W):
  - 0 NOP: T2 nothing; done.
  - 1 LDA: T2 MAR <= op; T3 A <= RAM[MAR]; done.
  - 2 ADD: T2 MAR <= op; T3 B <= RAM[MAR]; T4 A <= A+B, flags; done.
  - 3 SUB: as ADD with T4 A <= A-B, computed as A + ~B + 1; flags.
  - 4 STA: T2 MAR <= op; T3 RAM[MAR] <= A; done.
  - 5 LDI: T2 A <= zero-extended full operand; done.
  - 6 JMP: T2 PC <= op; done.
  - 7 JC: T2 PC <= op if cf=1; done.
  - 8 JZ: T2 PC <= op if zf=1; done.
  - 0xE OUT: T2 out_o <= A; out_valid=1 for exactly that one clk cycle; done.
  - 0xF HLT: T2 state <= HALT, step <= T0; done.
  - 9..0xD: behave as NOP.
- Instruction lengths in ticks: NOP/LDI/JMP/JC/JZ/OUT/HLT 3; LDA/STA 4; ADD/SUB 5.
- Flags:
  - Updated only at ADD/SUB T4.
  - cf = carry out of the DATA_W-bit sum; for SUB, cf=1 means no borrow (A>=B).
  - zf = (result == 0).
  - Results are truncated to DATA_W.
- Jumps evaluate flags as held at T2, i.e. after any prior ADD/SUB.
- step_mode=1: after an instruction completes, state <= HALT. PC points to the next instruction; run_i resumes.
- After HLT, run_i resumes at PC+1 relative to the HLT address.
- tick=0 in RUN: all state holds; out_valid stays 0.
- clr asserted mid-instruction: immediate return to reset state; partial instruction discarded; RAM keeps any STA already committed.

Test Plan:
- Load RAM: 0:0x1E, 1:0x2F, 2:0xE0, 3:0xF0, 14:28, 15:14; pulse run_i; tick=1 continuously -> out_o=42 and out_valid pulses after the 12th tick edge; cf=0, zf=0; halted=1 after the 15th tick; pc_o=4.
- Program LDI 15, ADD 15 with RAM[15]=0xF1, OUT, HLT -> 0x0F+0xF1 = 0x100: out_o=0x00, cf=1, zf=1.
- Program SUB with A=5, B=7 then JC 10 -> result 0xFE, cf=0, jump not taken, pc_o continues sequentially; with A=7, B=5 -> cf=1, pc_o=10 after JC.
- step_mode=1, run_i pulses -> halted=1 after each instruction: after 4 ticks (LDA), then 5 ticks (ADD). prog_we during RUN leaves RAM unchanged; prog_we during HALT writes.
- tick toggling 1-of-4 cycles -> same architectural results as continuous tick, with step_o advancing only on tick edges.
- Assert clr at ADD T3 -> all outputs 0 and halted=1 immediately; RAM unchanged; run_i re-executes from address 0. Also JMP 15 then fetch reads RAM[15], and PC increments wrap 15 -> 0.

Source files
------------

// File: rtl/sap_core.sv
// SAP-class accumulator CPU core: tick-enabled fetch/decode/execute sequencer,
// A/B registers, ALU with carry/zero flags, PC, MAR, IR, internal RAM and an
// output register, wrapped in a HALT/RUN state machine with single-step and
// a program-load port.
module sap_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4  // must not exceed DATA_W-4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              tick,
  input  logic              run_i,
  input  logic              step_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_o,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] a_o,
  output logic              cf,
  output logic              zf,
  output logic [2:0]        step_o
);

  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic {StHalt, StRun} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_out;
  logic                r_out_valid;
  logic                r_cf;
  logic                r_zf;
  logic [2:0]          r_step;
  logic [DATA_W-1:0]   r_ram [2**ADDR_W];

  logic [3:0]          w_opcode;
  logic [ADDR_W-1:0]   w_op_addr;
  logic [DATA_W-1:0]   w_op_ext;
  logic [2:0]          w_last_step;
  logic                w_done;
  logic                w_exec;
  logic                w_is_sub;
  logic [DATA_W-1:0]   w_b_op;
  logic [DATA_W:0]     w_sum;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;

  assign w_opcode  = r_ir[DATA_W-1 -: 4];
  assign w_op_addr = r_ir[ADDR_W-1:0];
  assign w_op_ext  = {{4{1'b0}}, r_ir[DATA_W-5:0]};
  assign w_exec    = (r_state == StRun) && tick;

  // Final micro-step of the current instruction (early step reset point)
  always_comb begin
    w_last_step = 3'd2;
    case (w_opcode)
      OpLda, OpSta: w_last_step = 3'd3;
      OpAdd, OpSub: w_last_step = 3'd4;
      default:      w_last_step = 3'd2;
    endcase
  end

  assign w_done = (r_step == w_last_step);

  // ALU: subtraction as A + ~B + 1 so carry means "no borrow"
  assign w_is_sub = (w_opcode == OpSub);
  assign w_b_op   = w_is_sub ? ~r_b : r_b;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, w_is_sub};

  // RAM write port arbitration: program load in HALT, STA at T3 in RUN
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = prog_addr;
    w_ram_wdata = prog_data;
    if (r_state == StHalt) begin
      w_ram_we = prog_we;
    end else if (w_exec && (r_step == 3'd3) && (w_opcode == OpSta)) begin
      w_ram_we    = 1'b1;
      w_ram_addr  = r_mar;
      w_ram_wdata = r_a;
    end
  end

  // RAM storage, deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_addr] <= w_ram_wdata;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= StHalt;
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_cf        <= 1'b0;
      r_zf        <= 1'b0;
      r_step      <= 3'd0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        StHalt: begin
          if (run_i) begin
            r_state <= StRun;
            r_step  <= 3'd0;
          end
        end
        StRun: begin
          if (tick) begin
            case (r_step)
              3'd0: r_mar <= r_pc;
              3'd1: begin
                r_ir <= r_ram[r_mar];
                r_pc <= r_pc + 1'b1;
              end
              3'd2: begin
                case (w_opcode)
                  OpLda, OpAdd, OpSub, OpSta: r_mar <= w_op_addr;
                  OpLdi: r_a <= w_op_ext;
                  OpJmp: r_pc <= w_op_addr;
                  OpJc:  if (r_cf) r_pc <= w_op_addr;
                  OpJz:  if (r_zf) r_pc <= w_op_addr;
                  OpOut: begin
                    r_out       <= r_a;
                    r_out_valid <= 1'b1;
                  end
                  default: ;
                endcase
              end
              3'd3: begin
                if (w_opcode == OpLda) r_a <= r_ram[r_mar];
                if (w_is_sub || (w_opcode == OpAdd)) r_b <= r_ram[r_mar];
              end
              3'd4: begin
                r_a  <= w_sum[DATA_W-1:0];
                r_cf <= w_sum[DATA_W];
                r_zf <= (w_sum[DATA_W-1:0] == '0);
              end
              default: ;
            endcase
            if (w_done) begin
              r_step <= 3'd0;
              if (step_mode || (w_opcode == OpHlt)) r_state <= StHalt;
            end else begin
              r_step <= r_step + 3'd1;
            end
          end
        end
        default: r_state <= StHalt;
      endcase
    end
  end

  assign out_o     = r_out;
  assign out_valid = r_out_valid;
  assign halted    = (r_state == StHalt);
  assign pc_o      = r_pc;
  assign a_o       = r_a;
  assign cf        = r_cf;
  assign zf        = r_zf;
  assign step_o    = r_step;

endmodule
